// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, NOP constant and per-stage payload layouts
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] PIPE_NOP = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } de_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rt_val;
    logic [31:0] result;
    logic        branch;
  } em_payload_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and optional two-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state;
  logic [DATA_W-1:0] main;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = state != EMPTY;
  assign out_data  = main;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = state == FULL ? 2'd2 : state == BUSY ? 2'd1 : 2'd0;

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] skid;
    assign in_ready = state != FULL;
    // head plus overflow entry; a stalled head parks the next word in skid instead of blocking upstream
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= EMPTY;
        main  <= BUBBLE;
        skid  <= BUBBLE;
      end else if (flush) begin
        state <= EMPTY;
        main  <= BUBBLE;
        skid  <= BUBBLE;
      end else begin
        case (state)
          EMPTY: if (in_fire) begin
            main  <= in_data;
            state <= BUSY;
          end
          BUSY: if (in_fire && out_fire) main <= in_data;
          else if (in_fire) begin
            skid  <= in_data;
            state <= FULL;
          end else if (out_fire) state <= EMPTY;
          FULL: if (out_fire) begin
            main  <= skid;
            state <= BUSY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end else begin : g_pass
    assign in_ready = !out_valid || out_ready;
    // single entry; ready passes straight through from downstream so a draining head can be refilled
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= EMPTY;
        main  <= BUBBLE;
      end else if (flush) begin
        state <= EMPTY;
        main  <= BUBBLE;
      end else if (in_fire) begin
        main  <= in_data;
        state <= BUSY;
      end else if (out_fire) state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench running a SKID=0 lane and a SKID=1 lane side by side
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush[2];
  logic         in_valid[2];
  logic         in_ready[2];
  logic [W-1:0] in_data[2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic [W-1:0] out_data[2];
  logic [1:0]   occupancy[2];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d actual=%h required=%h t=%0t", name, lane, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    pipe_stage_reg #(.DATA_W(W), .SKID(g == 1)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_data(in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g]),
      .occupancy(occupancy[g])
    );

    // reference: a FIFO of capacity 2 (SKID=1) or 1 with pass-through ready (SKID=0)
    logic [W-1:0] q[$];
    bit           bub = 1'b1;
    logic         exp_ir;
    logic         exp_ov;

    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        bub = 1'b1;
      end
      exp_ov = q.size() != 0;
      exp_ir = (g == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready[g]);
      chk("mon_out_valid", g, {31'b0, out_valid[g]}, {31'b0, exp_ov});
      chk("mon_in_ready", g, {31'b0, in_ready[g]}, {31'b0, exp_ir});
      chk("mon_occupancy", g, {30'b0, occupancy[g]}, q.size());
      if (exp_ov) chk("mon_out_data", g, out_data[g], q[0]);
      else if (bub) chk("mon_bubble", g, out_data[g], 32'h0);
      if (reset) begin
        if (flush[g]) begin
          q.delete();
          bub = 1'b1;
        end else begin
          if (exp_ov && out_ready[g]) void'(q.pop_front());
          if (in_valid[g] && exp_ir) begin
            q.push_back(in_data[g]);
            bub = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = v;
      in_data[k]   = d;
      out_ready[k] = r;
      flush[k]     = f;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_out_valid"}, k, {31'b0, out_valid[k]}, 32'h0);
      chk({name, "_in_ready"}, k, {31'b0, in_ready[k]}, 32'h1);
      chk({name, "_occupancy"}, k, {30'b0, occupancy[k]}, 32'h0);
      chk({name, "_out_data"}, k, out_data[k], 32'h0);
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (3) step;
    chk_idle("reset");
    reset = 1'b1;

    drive(1'b1, 32'h0000_3000, 1'b1, 1'b0);
    step;
    for (int k = 0; k < 2; k++) begin
      chk("fill_valid", k, {31'b0, out_valid[k]}, 32'h1);
      chk("fill_data", k, out_data[k], 32'h0000_3000);
    end

    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step;
      for (int k = 0; k < 2; k++) begin
        chk("stream_valid", k, {31'b0, out_valid[k]}, 32'h1);
        chk("stream_data", k, out_data[k], i);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step;

    drive(1'b1, 32'hA, 1'b1, 1'b0);
    step;
    chk("skid_a", 1, out_data[1], 32'hA);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step;
    chk("skid_occ", 1, {30'b0, occupancy[1]}, 32'h2);
    chk("skid_in_ready", 1, {31'b0, in_ready[1]}, 32'h0);
    chk("skid_head", 1, out_data[1], 32'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    step;
    chk("skid_b", 1, out_data[1], 32'hB);
    chk("skid_b_occ", 1, {30'b0, occupancy[1]}, 32'h1);
    chk("skid_ready_back", 1, {31'b0, in_ready[1]}, 32'h1);
    step;

    drive(1'b1, 32'hA, 1'b1, 1'b0);
    step;
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step;
    chk("flush_pre_occ", 1, {30'b0, occupancy[1]}, 32'h2);
    drive(1'b1, 32'hC, 1'b1, 1'b1);
    step;
    chk_idle("flush");
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) step;
    chk("flush_no_c", 1, {31'b0, out_valid[1]}, 32'h0);

    drive(1'b1, 32'hA, 1'b1, 1'b0);
    step;
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    step;
    chk("async_pre_occ", 1, {30'b0, occupancy[1]}, 32'h2);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async");
    step;
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) step;
    chk("async_no_stale", 1, {31'b0, out_valid[1]}, 32'h0);

    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        in_data[k]   = $urandom;
        out_ready[k] = 1'($urandom_range(0, 1));
        flush[k]     = $urandom_range(0, 49) == 0;
      end
      step;
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step;
    chk("drain_empty0", 0, {31'b0, out_valid[0]}, 32'h0);
    chk("drain_empty1", 1, {31'b0, out_valid[1]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register for the CPU datapath. It is the successor to the fixed-field stage registers: the payload is one packed vector of width DATA_W, so PC, instr, operands and flags are concatenated by the instantiating stage. It adds valid/ready handshaking, stall back-pressure, flush-to-bubble, and an optional two-entry skid buffer that cuts the combinational ready path between stages.

Parameters:
DATA_W, 32, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid buffer with ready driven from state only; 0 = single register with pass-through ready
BUBBLE, {DATA_W{1'b0}}, value loaded into the data registers on reset and on flush (all-zero = NOP encoding)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
flush  in  1  synchronous: discard all held entries this cycle
in_valid  in  1  upstream presents in_data
in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data holds a valid entry
out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready
out_data  out  DATA_W  head entry payload
occupancy  out  2  number of held entries, 0..2

Behaviour:
- Storage: main register (head) and skid register (the skid register exists only when SKID=1). out_data is always main.
- States: EMPTY (0 entries), BUSY (1 entry), FULL (2 entries; SKID=1 only). occupancy = 0/1/2 respectively.
- Outputs: out_valid = (state != EMPTY). For SKID=1, in_ready = (state != FULL), a function of state only with no path from out_ready. For SKID=0, in_ready = !out_valid || out_ready (combinational).
- Reset (reset=0, asynchronous): state=EMPTY, main=skid=BUBBLE, out_valid=0, occupancy=0, in_ready=1. This holds for the whole reset interval. Reset asserted mid-transfer drops all entries.
- In the transitions below, in_fire = in_valid && in_ready and out_fire = out_valid && out_ready.
- EMPTY: in_fire -> BUSY with main<=in_data. Otherwise stay in EMPTY.
- BUSY, in_fire && out_fire -> BUSY with main<=in_data (full throughput, 1 entry per cycle).
- BUSY, in_fire && !out_ready -> FULL with skid<=in_data and main held. With SKID=0 this case cannot occur, because in_ready=0 then.
- BUSY, !in_fire && out_fire -> EMPTY. main keeps its stale value; it is not reloaded with BUBBLE.
- BUSY, no fire -> hold.
- FULL: in_ready=0. out_fire -> BUSY with main<=skid. No out_fire -> hold both registers.
- Flush has the highest priority over every transition. Next state is EMPTY and main=skid=BUBBLE. An in_data presented in the flush cycle is discarded even if in_valid && in_ready. An out_fire in the flush cycle still counts as consumed by downstream. in_ready=1 from the next cycle.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY. Throughput: 1 transfer per cycle in steady state for both SKID values.
- Ordering: strict FIFO. The skid entry is never presented before main.
- Data width: payload passes bit-exact with no arithmetic. Bits are never reordered.
- X-safety: with in_valid=0 no register is loaded. Registers are never written from an X in_data while in_valid=0.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, BUSY, FULL};
  - constant PIPE_NOP = 32'h0;
  - packed struct typedefs per stage payload (for example the E->M payload of PC, instr, rt value, calc result, branch flag; 32+32+32+32+1 = 129 bits), so instantiators set DATA_W=$bits(struct).
- No sub-module. The FSM and datapath are one small block; SKID is selected by a generate branch.

Test Plan:
- Reset and fill: hold reset=0 for 3 cycles; check out_valid=0, in_ready=1, occupancy=0, out_data=0. Release reset, then in_valid=1, in_data=32'h0000_3000 with out_ready=1 -> next cycle out_valid=1 and out_data=32'h0000_3000.
- Streaming: send 8 words 1..8 back-to-back with out_ready=1 -> out_data shows 1..8 on consecutive cycles with no bubbles, for both SKID=0 and SKID=1.
- Stall/skid (SKID=1): in BUSY holding A=32'hA, drop out_ready and send B=32'hB -> FULL, occupancy=2, in_ready=0 the next cycle. Raise out_ready -> A then B emerge in order, in_ready returns to 1.
- Flush: in FULL, assert flush together with in_valid=1 and in_data=32'hC -> next cycle EMPTY, out_valid=0, out_data=BUBBLE (0), 32'hC never appears at the output.
- Async reset mid-operation: pull reset low between clock edges while FULL -> outputs go to reset values immediately, without waiting for a clock edge. No stale entry appears after release.
- Random back-pressure: 1000 cycles of random in_valid/out_ready with a scoreboard -> no loss, no duplication, order preserved, occupancy always 0..2.
